// File: rtl/cond_status_unit.sv
// cond_status_unit
//   NZCV-style status register with masked updates, a circular checkpoint
//   stack for branch-flush rollback, and NUM_SLOTS independent condition
//   evaluators with a registered one-cycle result.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   flag_we            apply masked flag update this cycle
//   flag_in/flag_mask  new flags / per-bit enable, packed {Z,C,N,V}
//   cond_req/cond      per-slot query valid / 4-bit ARM condition code
//   ckpt_push/pop      save current flags / restore flags from stack top
//   sr                 current flags {Z,C,N,V}
//   cond_valid/pass    registered per-slot result, pass gated by valid
//   ckpt_count         entries held; ckpt_full / ckpt_empty derived from it
//   ckpt_ovf           sticky: a push overwrote the oldest entry
//   ckpt_unf           one-cycle pulse after a pop on an empty stack

// Single-slot condition decoder. Odd codes are the complement of the even
// code below them (NE = !EQ, LS = !HI, ..., NV = !AL), so only the eight
// base predicates are decoded and bit 0 inverts.
module cond_lane (
  input  logic [3:0] flags,
  input  logic [3:0] code,
  output logic       pass
);
  logic z, c, n, v;
  logic base;

  assign z = flags[3];
  assign c = flags[2];
  assign n = flags[1];
  assign v = flags[0];

  always_comb begin
    base = 1'b0;
    unique case (code[3:1])
      3'd0: base = z;                  // EQ / NE
      3'd1: base = c;                  // CS / CC
      3'd2: base = n;                  // MI / PL
      3'd3: base = v;                  // VS / VC
      3'd4: base = c & ~z;             // HI / LS
      3'd5: base = (n == v);           // GE / LT
      3'd6: base = ~z & (n == v);      // GT / LE
      3'd7: base = 1'b1;               // AL / NV
      default: base = 1'b0;
    endcase
  end

  assign pass = base ^ code[0];
endmodule

module cond_status_unit #(
  parameter int NUM_SLOTS  = 2,
  parameter int CKPT_DEPTH = 4,
  parameter int FWD        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flag_we,
  input  logic [3:0]                    flag_in,
  input  logic [3:0]                    flag_mask,
  input  logic [NUM_SLOTS-1:0]          cond_req,
  input  logic [4*NUM_SLOTS-1:0]        cond,
  input  logic                          ckpt_push,
  input  logic                          ckpt_pop,
  output logic [3:0]                    sr,
  output logic [NUM_SLOTS-1:0]          cond_valid,
  output logic [NUM_SLOTS-1:0]          cond_pass,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
  output logic                          ckpt_full,
  output logic                          ckpt_empty,
  output logic                          ckpt_ovf,
  output logic                          ckpt_unf
);
  localparam int PW = $clog2(CKPT_DEPTH);
  localparam int CW = PW + 1;

  // Elaboration-time parameter guards.
  if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_slots
    $error("NUM_SLOTS must be 1..8");
  end
  if (CKPT_DEPTH < 2 || CKPT_DEPTH > 16 || (CKPT_DEPTH & (CKPT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CKPT_DEPTH must be a power of two in 2..16");
  end

  // Stack storage: wp is the next write slot. Because the depth is a power
  // of two, the pointer wraps naturally, and a push onto a full stack lands
  // on the oldest entry, which gives the circular overwrite for free.
  logic [3:0]    stk [CKPT_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] top_idx;
  logic [3:0]    top_val;

  logic          pop_ok;
  logic          pop_unf;
  logic          push_ok;
  logic [3:0]    sr_next;
  logic [3:0]    eval_flags;
  logic [NUM_SLOTS-1:0] pass_vec;

  assign ckpt_empty = (ckpt_count == '0);
  assign ckpt_full  = (ckpt_count == CW'(CKPT_DEPTH));

  assign top_idx = wp - 1'b1;
  assign top_val = stk[top_idx];

  // Pop wins over both push and update; a push is dropped whenever a pop is
  // requested, even if that pop underflows.
  assign pop_ok  = ckpt_pop & ~ckpt_empty;
  assign pop_unf = ckpt_pop &  ckpt_empty;
  assign push_ok = ckpt_push & ~ckpt_pop;

  always_comb begin
    sr_next = sr;
    if (pop_ok)
      sr_next = top_val;
    else if (flag_we)
      sr_next = (sr & ~flag_mask) | (flag_in & flag_mask);
  end

  // Forwarding lets consumers see this cycle's flag producer without a
  // bubble; the non-forwarding build trades that for a shorter path.
  assign eval_flags = (FWD != 0) ? sr_next : sr;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
    cond_lane u_lane (
      .flags (eval_flags),
      .code  (cond[4*i +: 4]),
      .pass  (pass_vec[i])
    );
  end

  // Stack contents carry no reset; only the pointer and count matter.
  always_ff @(posedge clk) begin
    if (push_ok)
      stk[wp] <= sr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= 4'b0000;
      wp         <= '0;
      ckpt_count <= '0;
      ckpt_ovf   <= 1'b0;
      ckpt_unf   <= 1'b0;
      cond_valid <= '0;
      cond_pass  <= '0;
    end else begin
      sr         <= sr_next;
      ckpt_unf   <= pop_unf;
      cond_valid <= cond_req;
      cond_pass  <= cond_req & pass_vec;

      if (pop_ok) begin
        wp         <= top_idx;
        ckpt_count <= ckpt_count - CW'(1);
      end else if (push_ok) begin
        wp <= wp + 1'b1;
        if (ckpt_full)
          ckpt_ovf <= 1'b1;
        else
          ckpt_count <= ckpt_count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cond_status_unit.sv
module tb_cond_status_unit;
  localparam int NS  = 2;
  localparam int D   = 4;
  localparam int CW  = $clog2(D) + 1;
  localparam int FWD = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flag_we;
  logic [3:0]      flag_in, flag_mask;
  logic [NS-1:0]   cond_req;
  logic [4*NS-1:0] cond;
  logic            ckpt_push, ckpt_pop;
  logic [3:0]      sr;
  logic [NS-1:0]   cond_valid, cond_pass;
  logic [CW-1:0]   ckpt_count;
  logic            ckpt_full, ckpt_empty, ckpt_ovf, ckpt_unf;

  cond_status_unit #(.NUM_SLOTS(NS), .CKPT_DEPTH(D), .FWD(FWD)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in),
    .flag_mask(flag_mask), .cond_req(cond_req), .cond(cond),
    .ckpt_push(ckpt_push), .ckpt_pop(ckpt_pop), .sr(sr),
    .cond_valid(cond_valid), .cond_pass(cond_pass), .ckpt_count(ckpt_count),
    .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty), .ckpt_ovf(ckpt_ovf),
    .ckpt_unf(ckpt_unf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [NS-1:0] req; logic [NS-1:0] pass; } exp_t;
  exp_t       q[$];
  logic [3:0] m_sr;
  logic [3:0] m_stk[$];
  bit         m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: conditions written straight from the ARM table.
  function automatic bit cond_true(input logic [3:0] f, input logic [3:0] c);
    bit z, cf, n, v;
    z = f[3]; cf = f[2]; n = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr = 4'b0000; m_stk.delete(); m_ovf = 0; m_unf = 0; q.delete();
  endtask

  task automatic idle_inputs();
    flag_we = 0; flag_in = 0; flag_mask = 0; cond_req = 0; cond = 0;
    ckpt_push = 0; ckpt_pop = 0;
  endtask

  // Drive one cycle of stimulus and advance the reference model.
  task automatic step(input logic we, input logic [3:0] fin, input logic [3:0] fm,
                      input logic [NS-1:0] req, input logic [4*NS-1:0] cd,
                      input logic push, input logic pop);
    logic [3:0] old, nsr, f;
    exp_t e;
    @(negedge clk);
    flag_we = we; flag_in = fin; flag_mask = fm; cond_req = req; cond = cd;
    ckpt_push = push; ckpt_pop = pop;
    old = m_sr; nsr = old; m_unf = 0;
    if (pop) begin
      if (m_stk.size() > 0) nsr = m_stk.pop_back();
      else begin
        m_unf = 1;
        if (we) nsr = (old & ~fm) | (fin & fm);
      end
    end else begin
      if (we) nsr = (old & ~fm) | (fin & fm);
      if (push) begin
        m_stk.push_back(old);
        if (m_stk.size() > D) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
      end
    end
    f = FWD ? nsr : old;
    e.req = req; e.pass = '0;
    for (int i = 0; i < NS; i++)
      if (req[i]) e.pass[i] = cond_true(f, cd[4*i +: 4]);
    if (|req) q.push_back(e);
    m_sr = nsr;
  endtask

  task automatic mid_reset();
    #2 rst = 0;
    idle_inputs();
    model_reset();
    #1;
    chk("async_rst_valid", 32'(cond_valid), 0);
    chk("async_rst_sr", 32'(sr), 0);
    chk("async_rst_count", 32'(ckpt_count), 0);
    chk("async_rst_empty", 32'(ckpt_empty), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  // Monitor: compares architectural state every cycle and pops a scoreboard
  // entry whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("sr", 32'(sr), 32'(m_sr));
      chk("count", 32'(ckpt_count), 32'(m_stk.size()));
      chk("full", 32'(ckpt_full), 32'(m_stk.size() == D));
      chk("empty", 32'(ckpt_empty), 32'(m_stk.size() == 0));
      chk("ovf", 32'(ckpt_ovf), 32'(m_ovf));
      chk("unf", 32'(ckpt_unf), 32'(m_unf));
      chk("pass_gated", 32'(cond_pass & ~cond_valid), 0);
      if (|cond_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 32'(cond_valid), 0);
        else begin
          e = q.pop_front();
          chk("cond_valid", 32'(cond_valid), 32'(e.req));
          chk("cond_pass", 32'(cond_pass), 32'(e.pass));
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("missing_valid", 32'(cond_valid), 32'(e.req));
      end
    end
  end

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sr", 32'(sr), 0);
    chk("rst_empty", 32'(ckpt_empty), 1);
    chk("rst_full", 32'(ckpt_full), 0);
    chk("rst_ovf_unf", 32'({ckpt_ovf, ckpt_unf}), 0);
    chk("rst_cond", 32'({cond_valid, cond_pass}), 0);
    rst = 1;

    // Masked update, then HI on the result.
    step(1, 4'hF, 4'b0101, 0, 0, 0, 0);
    @(posedge clk); #2 chk("masked_sr", 32'(sr), 32'h5);
    step(0, 0, 0, 2'b01, 8'h08, 0, 0);
    @(posedge clk); #2 chk("hi_pass", 32'(cond_pass[0]), 1);

    // Forwarding: EQ sees Z set in the same cycle.
    step(1, 4'h0, 4'hF, 0, 0, 0, 0);
    step(1, 4'b1000, 4'hF, 2'b01, 8'h00, 0, 0);
    @(posedge clk); #2 chk("fwd_eq", 32'(cond_pass[0]), 1);

    // Full sweep; slot 1 takes a different code to exercise both lanes.
    for (int s = 0; s < 16; s++)
      for (int c = 0; c < 16; c++)
        step(1, 4'(s), 4'hF, 2'b11, {4'(c ^ s), 4'(c)}, 0, 0);
    step(1, 4'b0011, 4'hF, 2'b01, 8'h0D, 0, 0);
    @(posedge clk); #2 chk("le_nv_eq", 32'(cond_pass[0]), 0);
    step(1, 4'b0010, 4'hF, 2'b01, 8'h0D, 0, 0);
    @(posedge clk); #2 chk("le_nv_ne", 32'(cond_pass[0]), 1);

    // Checkpoint rollback.
    step(1, 4'b1000, 4'hF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #2 chk("rb_count1", 32'(ckpt_count), 1);
    step(1, 4'b0010, 4'hF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #2 chk("rb_sr", 32'(sr), 32'h8);
    chk("rb_empty", 32'({ckpt_count, ckpt_empty}), 32'({3'd0, 1'b1}));

    // Overflow: D+1 distinct pushes, then drain newest first.
    step(0, 0, 0, 0, 0, 0, 0);
    mid_reset();
    for (int k = 1; k <= D + 1; k++) begin
      step(1, 4'(k), 4'hF, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    @(posedge clk); #2 chk("ovf_state", 32'({ckpt_count, ckpt_full, ckpt_ovf}), 32'({3'(D), 2'b11}));
    for (int k = D + 1; k >= 2; k--) begin
      step(0, 0, 0, 0, 0, 0, 1);
      @(posedge clk); #2 chk("drain_sr", 32'(sr), 32'(k));
    end
    step(1, 4'hF, 4'b0001, 0, 0, 0, 1);   // underflow; update still applies
    @(posedge clk); #2 chk("unf_pulse", 32'({ckpt_unf, sr}), 32'({1'b1, 4'h3}));
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2 chk("unf_clear", 32'(ckpt_unf), 0);

    // Collision: push+pop+update with top=0100.
    step(1, 4'b0100, 4'hF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 4'b1001, 4'hF, 0, 0, 0, 0);
    step(1, 4'hF, 4'hF, 2'b11, 8'h0E, 1, 1);
    @(posedge clk); #2 chk("coll", 32'({sr, ckpt_count}), 32'({4'b0100, 3'd0}));

    // Random traffic with a reset in the middle of back-to-back requests.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           NS'($urandom), (4*NS)'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
      if (i == 700) begin
        step(0, 0, 0, 2'b11, 8'h EE, 0, 0);
        mid_reset();
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cond_status_unit.md
# cond_status_unit

Parametrised NZCV status register plus multi-slot condition evaluator for the ARM-style pipeline. It holds architectural flags, applies masked flag updates from the execute stage, and evaluates up to NUM_SLOTS 4-bit condition fields per cycle with a registered, one-cycle result. A checkpoint stack of the flags supports branch-flush rollback. It sits between execute (flag producer) and the issue/writeback gating logic (condition consumers).

## Interface
- NUM_SLOTS, 2: number of independent condition-query slots (1..8).
- CKPT_DEPTH, 4: checkpoint stack entries (power of two, 2..16).
- FWD, 1: 1 = queries see flags as they will be after this cycle's update; 0 = queries see the current register value.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flag_we  in  1  apply flag update this cycle.
- flag_in  in  4  new flags, packed {Z,C,N,V}.
- flag_mask  in  4  per-bit write enable, same packing; 1 = bit updated.
- cond_req  in  NUM_SLOTS  query valid per slot.
- cond  in  4*NUM_SLOTS  condition codes; slot i at [4i+3:4i].
- ckpt_push  in  1  save current flags on stack.
- ckpt_pop  in  1  restore flags from stack top.
- sr  out  4  current flags {Z,C,N,V}.
- cond_valid  out  NUM_SLOTS  result valid per slot.
- cond_pass  out  NUM_SLOTS  condition result per slot.
- ckpt_count  out  $clog2(CKPT_DEPTH)+1  entries held.
- ckpt_full  out  1  count == CKPT_DEPTH.
- ckpt_empty  out  1  count == 0.
- ckpt_ovf  out  1  sticky: a push discarded the oldest entry.
- ckpt_unf  out  1  one-cycle pulse: pop attempted when empty.

## Operation
- Reset (rst low, async): sr=0000, stack count=0, ckpt_empty=1, ckpt_full=0, ckpt_ovf=0, ckpt_unf=0, cond_valid=0, cond_pass=0. Stack contents are don't-care.
- Flag update: if flag_we and not a successful pop, sr_next = (sr & ~flag_mask) | (flag_in & flag_mask).
- Pop, when not empty: sr_next = stack top, count decrements, and any same-cycle flag_we is discarded. Pop has priority over flag_we and push.
- Pop when empty: sr unchanged and ckpt_unf pulses. flag_we still applies.
- Push, with no pop in the same cycle: saves the pre-update sr (value at this edge), count increments.
- Push when full: circular stack; the oldest entry is overwritten, count stays at CKPT_DEPTH, ckpt_ovf sets and stays set until reset.
- Push and pop in the same cycle: pop executes and push is dropped silently.
- Evaluation flags F: FWD=1 uses sr_next; FWD=0 uses sr.
- Condition encoding (ARM):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- Slots are fully independent; all slots may query the same flags in one cycle.

## Timing
- Query latency 1: cond_req[i] at edge t gives cond_valid[i]=1 and cond_pass[i] at t+1 for exactly one cycle per request.
- cond_pass[i] is 0 whenever cond_valid[i] is 0.
- Back-to-back requests every cycle are supported with no bubbles.
- sr reflects an update or pop one cycle after the requesting edge.
- ckpt_count, ckpt_full, ckpt_empty and ckpt_ovf are registered and update with sr.
- ckpt_unf is a registered pulse in the cycle after the failed pop.
- Reset asserted mid-operation clears everything immediately; in-flight results are lost and cond_valid drops asynchronously.

## Test plan
- Reset then masked update: flag_we=1, flag_in=1111, flag_mask=0101 -> sr=0101 ({Z=0,C=1,N=0,V=1}) next cycle. A query with cond=8 (HI) in the following cycle -> pass=1.
- Forwarding: sr=0000; in the same cycle flag_we=1, flag_in=1000, mask=1111 and slot0 cond=0 (EQ). FWD=1 -> pass=1; FWD=0 -> pass=0.
- Full condition sweep: for every sr in 0000..1111 and cond 0..F on slot 0 -> pass matches the encoding list (check LE: Z=0,N=1,V=1 -> 0; Z=0,N=1,V=0 -> 1).
- Checkpoint rollback: sr=1000, push, update sr to 0010, pop -> sr=1000, count 1 -> 0, ckpt_empty=1.
- Overflow and underflow: CKPT_DEPTH+1 pushes with distinct sr values -> count=CKPT_DEPTH and ckpt_ovf=1; popping all restores newest first and the first value is lost. One extra pop -> ckpt_unf pulses once and sr is unchanged.
- Collisions: push+pop+flag_we in one cycle with top=0100 -> sr=0100, count decremented, and the update and push are dropped. Asserting rst mid-stream -> all outputs at reset values asynchronously.
